// File: rtl/fft_band_sink_if.sv
// Avalon-ST style streaming bundle carrying complex FFT beats into the band sink.
interface fft_band_sink_if #(
    parameter int DW = 16
);
    logic              valid;
    logic              ready;
    logic              sop;
    logic              eop;
    logic [2*DW-1:0]   data;
    logic [1:0]        error;

    modport master (output valid, output sop, output eop, output data, output error, input ready);
    modport slave  (input valid, input sop, input eop, input data, input error, output ready);
endinterface

// File: rtl/fft_band_sink.sv
// Spectrum packet sink: folds |re|+|im| of the leading bins into per-band peaks
// and publishes the band vector once per well-framed packet.
//
// state     | meaning
// S_IDLE    | waiting for a start-of-packet beat
// S_RECV    | capturing beats, tracking band peaks and frame errors
// S_PUBLISH | one cycle: copy working bands to the output, strobe done
module fft_band_sink #(
    parameter int FRAME_LEN = 512,
    parameter int BINS_USED = 256,
    parameter int NUM_BANDS = 32,
    parameter int DW        = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    fft_band_sink_if.slave               st,
    input  logic                         i_stall,
    output logic [NUM_BANDS-1:0][DW-1:0] o_bands,
    output logic                         o_frame_done,
    output logic [1:0]                   o_err
);
    localparam int              CW       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int              BPB      = BINS_USED / NUM_BANDS;
    localparam logic [CW-1:0]   LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic [CW:0]     BINS_LIM = (CW+1)'(BINS_USED);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_PUBLISH} state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [NUM_BANDS-1:0][DW-1:0]  work_q, work_d;
    logic [NUM_BANDS-1:0][DW-1:0]  bands_q, bands_d;
    logic                          ferr_q, ferr_d;
    logic                          done_q, done_d;
    logic [1:0]                    err_q, err_d;

    logic                          accept;
    logic signed [DW:0]            re_x, im_x;
    logic [DW:0]                   re_abs, im_abs, mag_sum;
    logic [DW-1:0]                 mag;
    logic [CW-1:0]                 idx, band_sel;
    logic                          beat_err;

    assign st.ready = !i_stall && (state_q != S_PUBLISH);
    assign accept   = st.valid && st.ready;
    assign beat_err = |st.error;

    // One extra bit so that |-2^(DW-1)| and the sum of two such values are exact.
    assign re_x    = {st.data[2*DW-1], st.data[2*DW-1:DW]};
    assign im_x    = {st.data[DW-1], st.data[DW-1:0]};
    assign re_abs  = re_x[DW] ? -re_x : re_x;
    assign im_abs  = im_x[DW] ? -im_x : im_x;
    assign mag_sum = re_abs + im_abs;
    assign mag     = mag_sum[DW] ? '1 : mag_sum[DW-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        ferr_d   = ferr_q;
        bands_d  = bands_q;
        done_d   = 1'b0;
        err_d    = err_q;
        idx      = cnt_q;
        band_sel = '0;

        if (state_q == S_PUBLISH) begin
            bands_d = work_q;
            done_d  = 1'b1;
            err_d   = {ferr_q, 1'b0};
            cnt_d   = '0;
            state_d = S_IDLE;
        end else if (accept && (st.sop || state_q == S_RECV)) begin
            // SOP always restarts capture; in S_RECV it also reports the aborted frame.
            if (st.sop) begin
                if (state_q == S_RECV) begin
                    err_d = {ferr_q, 1'b1};
                end
                idx    = '0;
                work_d = '0;
                ferr_d = 1'b0;
            end
            ferr_d   = ferr_d | beat_err;
            band_sel = idx / CW'(BPB);
            if ({1'b0, idx} < BINS_LIM) begin
                for (int i = 0; i < NUM_BANDS; i++) begin
                    if (band_sel == CW'(i) && mag > work_d[i]) begin
                        work_d[i] = mag;
                    end
                end
            end
            if (idx == LAST_IDX && st.eop) begin
                cnt_d   = '0;
                state_d = S_PUBLISH;
            end else if (idx == LAST_IDX || st.eop) begin
                err_d   = {ferr_d, 1'b1};
                cnt_d   = '0;
                state_d = S_IDLE;
            end else begin
                cnt_d   = idx + CW'(1);
                state_d = S_RECV;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            ferr_q  <= 1'b0;
            bands_q <= '0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            ferr_q  <= ferr_d;
            bands_q <= bands_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign o_bands      = bands_q;
    assign o_frame_done = done_q;
    assign o_err        = err_q;
endmodule

// File: tb/tb_fft_band_sink.sv
// Self-checking bench for fft_band_sink: frame-level reference model of band peaks
// plus timing checks on publish, abort, restart, stall and reset behaviour.
module tb_fft_band_sink;
    localparam int FL = 512;
    localparam int BU = 256;
    localparam int NB = 32;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic [NB-1:0][DW-1:0] bands;
    logic done;
    logic [1:0] err;

    fft_band_sink_if #(.DW(DW)) bus();

    fft_band_sink #(.FRAME_LEN(FL), .BINS_USED(BU), .NUM_BANDS(NB), .DW(DW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .st(bus), .i_stall(stall),
        .o_bands(bands), .o_frame_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int stall_pct = 0;
    int gap_pct = 0;
    int fr_re[FL];
    int fr_im[FL];
    logic [1:0] fr_err[FL];
    logic [NB-1:0][DW-1:0] exp_vec, prev_vec;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (bus.valid && bus.ready) acc_cnt <= acc_cnt + 1;
    end

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Band k holds the largest saturated |re|+|im| over bins 8k..8k+7.
    function automatic void model();
        int m;
        exp_vec = '0;
        for (int b = 0; b < BU; b++) begin
            m = iabs(fr_re[b]) + iabs(fr_im[b]);
            if (m > 65535) m = 65535;
            if (m > int'(exp_vec[b / (BU / NB)])) exp_vec[b / (BU / NB)] = m[15:0];
        end
    endfunction

    task automatic fill_zero();
        for (int b = 0; b < FL; b++) begin fr_re[b] = 0; fr_im[b] = 0; fr_err[b] = 2'b00; end
    endtask

    task automatic fill_random();
        for (int b = 0; b < FL; b++) begin
            fr_re[b] = int'($urandom_range(65535)) - 32768;
            fr_im[b] = int'($urandom_range(65535)) - 32768;
            fr_err[b] = 2'b00;
        end
    endtask

    task automatic send_beat(input int re, input int im, input bit sop, input bit eop, input logic [1:0] e);
        int tries = 0;
        bit acc = 0;
        for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
            @(posedge clk); #1;
        end
        bus.valid = 1'b1; bus.sop = sop; bus.eop = eop; bus.error = e;
        bus.data = {re[15:0], im[15:0]};
        while (!acc) begin
            stall = (int'($urandom_range(99)) < stall_pct);
            @(negedge clk);
            vectors++;
            if (stall && bus.ready) begin
                errors++; $display("FAIL ready_under_stall: got ready=%b want 0", bus.ready);
            end
            acc = bus.ready;
            @(posedge clk); #1;
            tries++;
            if (tries > 200) begin
                errors++; $display("FAIL beat_accept_timeout: got no acceptance want acceptance");
                acc = 1;
            end
        end
        bus.valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0; bus.error = 2'b00;
        stall = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int b = lo; b <= hi; b++) send_beat(fr_re[b], fr_im[b], b == 0, b == FL - 1, fr_err[b]);
    endtask

    task automatic test_reset();
        bus.valid = 1'b0; bus.sop = 1'b0; bus.eop = 1'b0; bus.data = '0; bus.error = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; #1;
        vectors++; if (bands !== '0) begin errors++; $display("FAIL rst_bands: got %h want 0", bands); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        vectors++; if (err !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", err); end
        vectors++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.ready); end
        stall = 1'b1; #1;
        vectors++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", bus.ready); end
        stall = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_peaks();
        int d0;
        fill_zero();
        for (int k = 0; k < NB; k++) begin fr_re[8*k+3] = 100 * (k + 1); fr_im[8*k+3] = -50; end
        model();
        d0 = done_cnt;
        send_range(0, FL - 1);
        vectors++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL peaks_pub_ready: got %b want 0", bus.ready); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL peaks_early_done: got %b want 0", done); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL peaks_done: got %b want 1", done); end
        vectors++; if (err !== 2'b00) begin errors++; $display("FAIL peaks_err: got %b want 00", err); end
        for (int k = 0; k < NB; k++) begin
            vectors++;
            if (int'(bands[k]) != 100 * (k + 1) + 50) begin
                errors++; $display("FAIL peaks_band%0d: got %0d want %0d", k, bands[k], 100 * (k + 1) + 50);
            end
        end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL peaks_done_clear: got %b want 0", done); end
        vectors++; if (done_cnt != d0 + 1) begin errors++; $display("FAIL peaks_done_count: got %0d want %0d", done_cnt - d0, 1); end
    endtask

    task automatic test_saturate();
        fill_zero();
        fr_re[0] = -32768; fr_im[0] = -32768; fr_re[300] = 32767;
        model();
        send_range(0, FL - 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done: got %b want 1", done); end
        vectors++; if (bands !== exp_vec) begin errors++; $display("FAIL sat_bands: got %h want %h", bands, exp_vec); end
        vectors++; if (bands[0] !== 16'hFFFF) begin errors++; $display("FAIL sat_band0: got %h want ffff", bands[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int d0;
        prev_vec = bands;
        d0 = done_cnt;
        fill_random();
        for (int b = 0; b <= 100; b++) send_beat(fr_re[b], fr_im[b], b == 0, b == 100, 2'b00);
        vectors++; if (err !== 2'b01) begin errors++; $display("FAIL abort_err: got %b want 01", err); end
        repeat (3) @(posedge clk); #1;
        vectors++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done: got %0d strobes want 0", done_cnt - d0); end
        vectors++; if (bands !== prev_vec) begin errors++; $display("FAIL abort_bands: got %h want %h", bands, prev_vec); end
        fill_random();
        model();
        send_range(0, FL - 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL after_abort_done: got %b want 1", done); end
        vectors++; if (bands !== exp_vec) begin errors++; $display("FAIL after_abort_bands: got %h want %h", bands, exp_vec); end
        vectors++; if (err !== 2'b00) begin errors++; $display("FAIL after_abort_err: got %b want 00", err); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int a0;
        stall_pct = 30; gap_pct = 20;
        fill_random();
        model();
        a0 = acc_cnt;
        send_range(0, FL - 1);
        stall_pct = 0; gap_pct = 0;
        vectors++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL stall_pub_ready: got %b want 0", bus.ready); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done: got %b want 1", done); end
        vectors++; if (bands !== exp_vec) begin errors++; $display("FAIL stall_bands: got %h want %h", bands, exp_vec); end
        vectors++; if (acc_cnt - a0 != FL) begin errors++; $display("FAIL stall_accepts: got %0d want %0d", acc_cnt - a0, FL); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL stall_done_clear: got %b want 0", done); end
    endtask

    task automatic test_error_restart();
        fill_random();
        fr_err[17] = 2'b10;
        model();
        send_range(0, FL - 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL uerr_done: got %b want 1", done); end
        vectors++; if (err !== 2'b10) begin errors++; $display("FAIL uerr_err: got %b want 10", err); end
        vectors++; if (bands !== exp_vec) begin errors++; $display("FAIL uerr_bands: got %h want %h", bands, exp_vec); end
        @(posedge clk); #1;
        fill_random();
        send_range(0, 39);
        fill_random();
        model();
        send_beat(fr_re[0], fr_im[0], 1'b1, 1'b0, 2'b00);
        vectors++; if (err !== 2'b01) begin errors++; $display("FAIL restart_err: got %b want 01", err); end
        send_range(1, FL - 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done: got %b want 1", done); end
        vectors++; if (err !== 2'b00) begin errors++; $display("FAIL restart_pub_err: got %b want 00", err); end
        vectors++; if (bands !== exp_vec) begin errors++; $display("FAIL restart_bands: got %h want %h", bands, exp_vec); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int d0;
        fill_random();
        send_range(0, 199);
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bands !== '0) begin errors++; $display("FAIL midrst_bands: got %h want 0", bands); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
        vectors++; if (err !== 2'b00) begin errors++; $display("FAIL midrst_err: got %b want 00", err); end
        @(negedge clk); rst_n = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 20; i++) send_beat(int'($urandom_range(65535)) - 32768, 1234, 1'b0, i == 10, 2'b11);
        repeat (3) @(posedge clk); #1;
        vectors++; if (err !== 2'b00) begin errors++; $display("FAIL nosop_err: got %b want 00", err); end
        vectors++; if (done_cnt != d0) begin errors++; $display("FAIL nosop_done: got %0d strobes want 0", done_cnt - d0); end
        fill_random();
        model();
        send_range(0, FL - 1);
        @(posedge clk); #1;
        vectors++; if (done !== 1'b1) begin errors++; $display("FAIL postrst_done: got %b want 1", done); end
        vectors++; if (bands !== exp_vec) begin errors++; $display("FAIL postrst_bands: got %h want %h", bands, exp_vec); end
        vectors++; if (err !== 2'b00) begin errors++; $display("FAIL postrst_err: got %b want 00", err); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_peaks();
        test_saturate();
        test_abort();
        test_stall();
        test_error_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got no completion want completion within 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
